// File: rtl/bus_master_port.sv
// bus_master_port: serial bus master FSM with split/resume; BUS_MASTER_TIMEOUT_EN enables the ACK timeout.
module bus_master_port #(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  M_EXECUTE,
    input  logic                  M_RW,
    input  logic [ADDR_WIDTH-1:0] M_ADDR,
    input  logic [DATA_WIDTH-1:0] M_DIN,
    output logic [DATA_WIDTH-1:0] M_DOUT,
    output logic                  M_DVALID,
    output logic                  M_BUSY,
    output logic                  M_ERR,
    output logic                  B_BREQ,
    input  logic                  B_GRANT,
    output logic                  B_MVALID,
    output logic                  B_RW,
    output logic                  B_BUS_OUT,
    input  logic                  B_BUS_IN,
    input  logic                  B_READY,
    input  logic                  B_ACK,
    input  logic                  B_SPLIT,
    input  logic                  B_SPL_RESUME
);
    localparam logic [3:0] IDLE = 4'd0, REQ = 4'd1, ADDR = 4'd2, AACK = 4'd3, WDATA = 4'd4,
                           WACK = 4'd5, RDATA = 4'd6, SPLIT = 4'd7, DONE = 4'd8;
    localparam int MW = ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(MW + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
`ifdef BUS_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic [3:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rw_q, rw_d;
    logic                  dvalid_q, dvalid_d;
    logic                  err_q, err_d;
    logic                  abort, to_hit, last_a, last_d;

    assign abort  = !B_GRANT && (state_q inside {ADDR, AACK, WDATA, WACK, RDATA});
    assign to_hit = TO_EN && (wcnt_q == TW'(ACK_TIMEOUT - 1));
    assign last_a = cnt_q == CW'(ADDR_WIDTH - 1);
    assign last_d = cnt_q == CW'(DATA_WIDTH - 1);

    // Address and write data are shifted out LSB first; read data is shifted in from the top.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        rdat_d   = rdat_q;
        dout_d   = dout_q;
        rw_d     = rw_q;
        dvalid_d = 1'b0;
        err_d    = 1'b0;
        if (abort) begin
            state_d = DONE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (M_EXECUTE) begin
                    state_d = REQ;
                    addr_d  = M_ADDR;
                    wdat_d  = M_DIN;
                    rw_d    = M_RW;
                end
                REQ: if (B_GRANT) begin
                    state_d = ADDR;
                    cnt_d   = '0;
                end
                ADDR: begin
                    addr_d = addr_q >> 1;
                    cnt_d  = cnt_q + CW'(1);
                    if (last_a) begin
                        state_d = AACK;
                        wcnt_d  = '0;
                    end
                end
                AACK: if (B_ACK) begin
                    state_d = rw_q ? WDATA : RDATA;
                    cnt_d   = '0;
                end else if (to_hit) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else wcnt_d = wcnt_q + TW'(1);
                WDATA: begin
                    wdat_d = wdat_q >> 1;
                    cnt_d  = cnt_q + CW'(1);
                    if (last_d) begin
                        state_d = WACK;
                        wcnt_d  = '0;
                    end
                end
                WACK: if (B_ACK) state_d = DONE;
                else if (to_hit) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else wcnt_d = wcnt_q + TW'(1);
                RDATA: if (B_SPLIT && !B_SPL_RESUME) state_d = SPLIT;
                else if (B_READY) begin
                    rdat_d = DATA_WIDTH'({B_BUS_IN, rdat_q} >> 1);
                    cnt_d  = cnt_q + CW'(1);
                    if (last_d) begin
                        state_d  = DONE;
                        dout_d   = rdat_d;
                        dvalid_d = 1'b1;
                    end
                end
                SPLIT: if (B_SPL_RESUME) begin
                    state_d = RDATA;
                    cnt_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            addr_q   <= '0;
            wdat_q   <= '0;
            rdat_q   <= '0;
            dout_q   <= '0;
            rw_q     <= 1'b0;
            dvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            rdat_q   <= rdat_d;
            dout_q   <= dout_d;
            rw_q     <= rw_d;
            dvalid_q <= dvalid_d;
            err_q    <= err_d;
        end
    end

    assign M_DOUT    = dout_q;
    assign M_DVALID  = dvalid_q;
    assign M_ERR     = err_q;
    assign M_BUSY    = state_q != IDLE;
    assign B_BREQ    = state_q inside {REQ, ADDR, AACK, WDATA, WACK, RDATA};
    assign B_MVALID  = state_q inside {ADDR, WDATA};
    assign B_RW      = M_BUSY && rw_q;
    assign B_BUS_OUT = state_q == ADDR ? addr_q[0] : state_q == WDATA ? wdat_q[0] : 1'b0;
endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: directed plus randomized transactions checked against expected serial streams.
module tb_bus_master_port;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          CLK = 1'b0, RSTN = 1'b0, M_EXECUTE = 1'b0, M_RW = 1'b0;
    logic [AW-1:0] M_ADDR = '0;
    logic [DW-1:0] M_DIN = '0;
    logic [DW-1:0] M_DOUT;
    logic          M_DVALID, M_BUSY, M_ERR, B_BREQ, B_MVALID, B_RW, B_BUS_OUT;
    logic          B_GRANT = 1'b0, B_BUS_IN = 1'b0, B_READY = 1'b0, B_ACK = 1'b0;
    logic          B_SPLIT = 1'b0, B_SPL_RESUME = 1'b0;
    int            checks = 0, errors = 0;
    logic [DW-1:0] last_dout = '0;

    bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACK_TIMEOUT(TO)) dut (
        .CLK(CLK), .RSTN(RSTN), .M_EXECUTE(M_EXECUTE), .M_RW(M_RW), .M_ADDR(M_ADDR),
        .M_DIN(M_DIN), .M_DOUT(M_DOUT), .M_DVALID(M_DVALID), .M_BUSY(M_BUSY), .M_ERR(M_ERR),
        .B_BREQ(B_BREQ), .B_GRANT(B_GRANT), .B_MVALID(B_MVALID), .B_RW(B_RW),
        .B_BUS_OUT(B_BUS_OUT), .B_BUS_IN(B_BUS_IN), .B_READY(B_READY), .B_ACK(B_ACK),
        .B_SPLIT(B_SPLIT), .B_SPL_RESUME(B_SPL_RESUME)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        check(tag, {M_BUSY, B_BREQ, B_MVALID, B_RW, B_BUS_OUT, M_DVALID, M_ERR}, 0);
        check({tag, "_dout"}, M_DOUT, last_dout);
    endtask

    // Issue a request, wait g cycles without grant (re-strobing M_EXECUTE), then grant.
    task automatic start(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d, input int g);
        B_GRANT = 1'b0;
        M_EXECUTE = 1'b1; M_RW = rw; M_ADDR = a; M_DIN = d;
        step();
        M_ADDR = AW'($urandom); M_DIN = DW'($urandom); M_RW = ~rw;
        M_EXECUTE = 1'b0;
        check("req", {M_BUSY, B_BREQ, B_MVALID, B_RW}, {1'b1, 1'b1, 1'b0, rw});
        for (int i = 0; i < g; i++) begin
            M_EXECUTE = 1'b1;
            step();
            check("req_wait", {M_BUSY, B_BREQ, B_MVALID, B_RW}, {1'b1, 1'b1, 1'b0, rw});
        end
        M_EXECUTE = 1'b0;
        B_GRANT = 1'b1;
        step();
    endtask

    task automatic send_addr(input logic [AW-1:0] a, input logic rw);
        for (int k = 0; k < AW; k++) begin
            check("addr_bit", {B_MVALID, B_BUS_OUT, B_RW}, {1'b1, a[k], rw});
            step();
        end
        check("aack", {B_MVALID, B_BUS_OUT, B_BREQ, M_BUSY}, 4'b0011);
    endtask

    task automatic ack(input int d);
        for (int i = 0; i < d; i++) step();
        B_ACK = 1'b1;
        step();
        B_ACK = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int g, input int d1, input int d2);
        start(1'b1, a, d, g);
        send_addr(a, 1'b1);
        ack(d1);
        for (int k = 0; k < DW; k++) begin
            check("wdata_bit", {B_MVALID, B_BUS_OUT}, {1'b1, d[k]});
            step();
        end
        check("wack", {B_MVALID, B_BUS_OUT, B_BREQ}, 3'b001);
        ack(d2);
        check("wdone", {M_BUSY, B_BREQ, B_MVALID, M_ERR, M_DVALID, B_RW}, 6'b100001);
        step();
        idle_check("wr_idle");
    endtask

    // Read w0; if split_at >= 0, split after that many bits and then the slave returns w1.
    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                           input int split_at, input bit all_ready);
        int i = 0, guard = 0;
        bit split_done = 1'b0;
        bit r;
        logic [DW-1:0] word = w0;
        start(1'b0, a, $urandom, $urandom_range(0, 2));
        send_addr(a, 1'b0);
        ack($urandom_range(0, TO - 1));
        while (i < DW && guard < 200) begin
            guard++;
            check("rdata", {M_DVALID, M_DOUT, B_BREQ, B_MVALID}, {1'b0, last_dout, 1'b1, 1'b0});
            if (i == split_at && !split_done) begin
                B_SPLIT = 1'b1; B_READY = 1'b1; B_BUS_IN = 1'($urandom);
                step();
                B_GRANT = 1'b0; B_READY = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    check("split", {B_BREQ, M_BUSY, B_MVALID, M_ERR}, 4'b0100);
                    if (c < 9) step();
                end
                B_SPLIT = 1'b0; B_SPL_RESUME = 1'b1; B_GRANT = 1'b1;
                step();
                B_SPL_RESUME = 1'b0;
                check("resume", {B_BREQ, M_BUSY}, 2'b11);
                i = 0; word = w1; split_done = 1'b1;
            end else begin
                r = all_ready || ($urandom_range(0, 2) != 0);
                B_READY = r;
                B_BUS_IN = r ? word[i] : 1'($urandom);
                step();
                if (r) i++;
            end
        end
        B_READY = 1'b0;
        check("rd_bound", i, DW);
        check("rdone", {M_DVALID, M_ERR, B_BREQ, M_BUSY, M_DOUT}, {4'b1001, word});
        last_dout = word;
        step();
        idle_check("rd_idle");
    endtask

    initial begin
        step();
        step();
        idle_check("reset");
        RSTN = 1'b1;
        step();
        idle_check("post_reset");

        do_write(14'h1ABC, 8'hA5, 0, 0, 0);
        do_read(14'h0005, 8'h3C, 8'h00, -1, 1'b1);
        do_read(AW'($urandom), DW'($urandom), 8'hC9, 3, 1'b0);

        for (int t = 0; t < 6; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(AW'($urandom), DW'($urandom), $urandom_range(0, 3), $urandom_range(0, TO - 1),
                         $urandom_range(0, TO - 1));
            else
                do_read(AW'($urandom), DW'($urandom), DW'($urandom),
                        ($urandom_range(0, 1) == 1) ? $urandom_range(0, DW - 1) : -1, 1'b0);
        end

        // grant lost in the middle of the address phase
        start(1'b1, 14'h2A5A, 8'h11, 1);
        for (int j = 0; j < 5; j++) begin
            check("abort_addr", B_MVALID, 1'b1);
            step();
        end
        B_GRANT = 1'b0;
        step();
        check("abort_done", {M_ERR, M_DVALID, B_BREQ, B_MVALID, M_BUSY}, 5'b10001);
        step();
        idle_check("abort_idle");

        // reset asserted in the middle of the write data phase
        start(1'b1, 14'h0F0F, 8'hFF, 0);
        send_addr(14'h0F0F, 1'b1);
        ack(0);
        step();
        step();
        check("wdata_mid", {B_MVALID, M_BUSY}, 2'b11);
        RSTN = 1'b0;
        step();
        last_dout = '0;
        idle_check("rst_mid");
        RSTN = 1'b1;
        step();
        idle_check("rst_release");

        // no acknowledge after the address phase
        start(1'b0, 14'h1234, 8'h00, 0);
        send_addr(14'h1234, 1'b0);
`ifdef BUS_MASTER_TIMEOUT_EN
        for (int c = 0; c < TO; c++) begin
            check("to_wait", {M_ERR, M_BUSY, B_BREQ}, 3'b011);
            step();
        end
        check("to_done", {M_ERR, M_DVALID, B_BREQ, M_BUSY}, 4'b1001);
        step();
        idle_check("to_idle");
`else
        for (int c = 0; c < 20; c++) begin
            check("aack_hold", {M_ERR, M_BUSY, B_BREQ}, 3'b011);
            step();
        end
        B_GRANT = 1'b0;
        step();
        check("hold_abort", {M_ERR, M_DVALID, B_BREQ, M_BUSY}, 4'b1001);
        step();
        idle_check("hold_idle");
`endif

        do_write(AW'($urandom), DW'($urandom), 2, 1, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
